// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock synchronous FIFO with full/empty flags and a
//               registered read port. Pointers carry one extra wrap bit so
//               full and empty can be told apart when the indices match.
//               Optional status outputs (count, sticky overflow/underflow)
//               are built when the macro SYNC_FIFO_STATUS_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty
`ifdef SYNC_FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] c_ptr_one = (ADDR_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wr_ptr;
    logic [ADDR_WIDTH:0]   r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_accept;
    logic                  w_rd_accept;

    // Flags depend only on the registered pointers, never on the requests.
    always_comb begin
        w_full  = (r_wr_ptr[ADDR_WIDTH-1:0] == r_rd_ptr[ADDR_WIDTH-1:0]) &&
                  (r_wr_ptr[ADDR_WIDTH] != r_rd_ptr[ADDR_WIDTH]);
        w_empty = (r_wr_ptr == r_rd_ptr);
        w_wr_accept = wr_en && !w_full;
        w_rd_accept = rd_en && !w_empty;
    end

    // Storage array; left uninitialised on reset since the pointers gate access.
    always_ff @(posedge clk) begin
        if (w_wr_accept && !rst) begin
            r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointer advance and registered read data; reset wins over both requests.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd_accept) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_rd_data <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            end
        end
    end

    assign rd_data = r_rd_data;
    assign full    = w_full;
    assign empty   = w_empty;

`ifdef SYNC_FIFO_STATUS_EN
    logic [ADDR_WIDTH:0] r_count;
    logic                r_overflow;
    logic                r_underflow;

    // Occupancy tracks accepted transfers; error flags stay set until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_accept && !w_rd_accept) begin
                r_count <= r_count + c_ptr_one;
            end else if (w_rd_accept && !w_wr_accept) begin
                r_count <= r_count - c_ptr_one;
            end
            if (wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Scoreboard bench for sync_fifo. A queue-based reference model
//               predicts accepted reads; a monitor compares rd_data one cycle
//               after each predicted read and checks hold behaviour otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_STATUS_EN
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty)
`ifdef SYNC_FIFO_STATUS_EN
        ,
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the FIFO and the queue of expected reads.
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] exp_q[$];
    logic          model_valid = 1'b0;
    logic          m_ovf = 1'b0;
    logic          m_unf = 1'b0;

    // Per-cycle intent published by the driver for the monitor.
    logic          tb_rd_acc = 1'b0;
    logic          tb_rst    = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // One stimulus cycle: check flags against the model, drive, update model.
    task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        logic wr_acc;
        int   sz;
        @(negedge clk);
        sz = model_q.size();
        if (model_valid) begin
            check("empty", 32'(empty), 32'(sz == 0));
            check("full", 32'(full), 32'(sz == DEPTH));
            check("not_both", 32'(full && empty), 32'd0);
`ifdef SYNC_FIFO_STATUS_EN
            check("count", 32'(count), 32'(sz));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("underflow", 32'(underflow), 32'(m_unf));
`endif
        end
        rst = r; wr_en = w; rd_en = rd; wr_data = d;
        if (r) begin
            model_q.delete();
            tb_rd_acc   = 1'b0;
            tb_rst      = 1'b1;
            model_valid = 1'b1;
            m_ovf       = 1'b0;
            m_unf       = 1'b0;
        end else begin
            tb_rst    = 1'b0;
            tb_rd_acc = rd && (sz > 0);
            wr_acc    = w && (sz < DEPTH);
            if (w && sz == DEPTH) m_ovf = 1'b1;
            if (rd && sz == 0)    m_unf = 1'b1;
            if (tb_rd_acc) exp_q.push_back(model_q.pop_front());
            if (wr_acc)    model_q.push_back(d);
        end
    endtask

    // Monitor: compares registered read data one cycle after each edge.
    initial begin
        logic          acc;
        logic          rs;
        logic          known;
        logic [DW-1:0] last_rd;
        logic [DW-1:0] e;
        known   = 1'b0;
        last_rd = '0;
        forever begin
            @(posedge clk);
            acc = tb_rd_acc;
            rs  = tb_rst;
            #1;
            if (rs) begin
                check("rd_data_reset", 32'(rd_data), 32'h0);
                last_rd = '0;
                known   = 1'b1;
            end else if (acc) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL scoreboard_underrun: got 0x%0h expected none", rd_data);
                end else begin
                    e = exp_q.pop_front();
                    check("rd_data", 32'(rd_data), 32'(e));
                    last_rd = e;
                end
            end else if (known) begin
                check("rd_data_hold", 32'(rd_data), 32'(last_rd));
            end
        end
    end

    initial begin
        logic          w_cur;
        logic          r_cur;
        int            w_hold;
        int            r_hold;
        int            w_bias;

        // Reset with both requests asserted: nothing may be written.
        step(1'b1, 1'b1, 1'b1, 8'hEE);
        step(1'b1, 1'b1, 1'b1, 8'hEF);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill to full, attempt an overflow write, then drain in order.
        for (int i = 1; i <= DEPTH; i++) step(1'b0, 1'b1, 1'b0, 8'(i));
        step(1'b0, 1'b1, 1'b0, 8'hAA);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        // Underflow reads: rd_data must hold the last value.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);

        // Five stored words, then concurrent read/write across pointer wrap.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b1, 8'($urandom));
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Both asserted while empty: only the write happens.
        step(1'b0, 1'b1, 1'b1, 8'h5A);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset mid-operation discards stored words.
        step(1'b0, 1'b1, 1'b0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 8'h22);
        step(1'b0, 1'b1, 1'b0, 8'h33);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b0, 8'h44);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);

        // Random traffic with requests held 1-3 cycles; bias drifts to hit both flags.
        w_cur = 1'b0; r_cur = 1'b0; w_hold = 0; r_hold = 0;
        for (int c = 0; c < 300; c++) begin
            w_bias = (c < 100) ? 3 : ((c < 200) ? 1 : 2);
            if (w_hold == 0) begin
                w_cur  = ($urandom_range(0, 3) < w_bias);
                w_hold = $urandom_range(1, 3);
            end
            if (r_hold == 0) begin
                r_cur  = ($urandom_range(0, 3) >= w_bias);
                r_hold = $urandom_range(1, 3);
            end
            step(1'b0, w_cur, r_cur, 8'($urandom));
            w_hold--;
            r_hold--;
        end

        // Drain remaining words and let the monitor catch up.
        for (int i = 0; i < DEPTH + 2; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b0, 1'b0, 8'h00);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
